// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed instruction store with a registered read port and a load port
module instruction_memory #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrBits  = 16,
  parameter int unsigned Depth     = 256,
  parameter string       InitFile  = ""
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [AddrBits-1:0]  ReadAddr,
  output logic [DataWidth-1:0] ReadData,
  input  logic                 WriteEn,
  input  logic [AddrBits-1:0]  WriteAddr,
  input  logic [DataWidth-1:0] WriteData,
  output logic                 AddrErr
);
  localparam int unsigned IdxBits = (Depth > 1) ? $clog2(Depth) : 1;
  logic [DataWidth-1:0] mem [Depth];
  logic                 rd_ok;
  logic                 wr_ok;
  logic [IdxBits-1:0]   rd_idx;
  logic [IdxBits-1:0]   wr_idx;
  always_comb begin
    rd_ok  = 32'(ReadAddr) < Depth;
    wr_ok  = 32'(WriteAddr) < Depth;
    rd_idx = ReadAddr[IdxBits-1:0];
    wr_idx = WriteAddr[IdxBits-1:0];
  end
  initial for (int i = 0; i < int'(Depth); i++) mem[i] = '0;
  always @(posedge CLK) if (RST_N && WriteEn && wr_ok) mem[wr_idx] <= WriteData;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ReadData <= '0;
      AddrErr  <= 1'b0;
    end else begin
      ReadData <= rd_ok ? mem[rd_idx] : '0;
      AddrErr  <= !rd_ok;
    end
  end
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed table, reset corners and randomized run against an array model
module tb_instruction_memory;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] ReadAddr;
    logic [15:0] ReadData;
    logic        WriteEn;
    logic [15:0] WriteAddr;
    logic [15:0] WriteData;
    logic        AddrErr;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [256];

    typedef struct {
        logic [15:0] ra;
        logic        we;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    instruction_memory dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData),
        .WriteEn   (WriteEn),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .AddrErr   (AddrErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [15:0] ra, input logic we, input logic [15:0] wa, input logic [15:0] wd);
        @(negedge CLK);
        ReadAddr  = ra;
        WriteEn   = we;
        WriteAddr = wa;
        WriteData = wd;
        @(posedge CLK);
        #1;
        if (we && wa < 16'd256) model[wa[7:0]] = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        vecs[0]  = '{16'd0,   1'b1, 16'd0,   16'h1234, 16'h0000, 1'b0};
        vecs[1]  = '{16'd0,   1'b1, 16'd1,   16'hABCD, 16'h1234, 1'b0};
        vecs[2]  = '{16'd0,   1'b1, 16'd2,   16'h0F0F, 16'h1234, 1'b0};
        vecs[3]  = '{16'd0,   1'b1, 16'd3,   16'hFFFF, 16'h1234, 1'b0};
        vecs[4]  = '{16'd0,   1'b0, 16'd0,   16'h0000, 16'h1234, 1'b0};
        vecs[5]  = '{16'd1,   1'b0, 16'd0,   16'h0000, 16'hABCD, 1'b0};
        vecs[6]  = '{16'd2,   1'b0, 16'd0,   16'h0000, 16'h0F0F, 1'b0};
        vecs[7]  = '{16'd3,   1'b0, 16'd0,   16'h0000, 16'hFFFF, 1'b0};
        vecs[8]  = '{16'd5,   1'b1, 16'd5,   16'h5555, 16'h0000, 1'b0};
        vecs[9]  = '{16'd5,   1'b0, 16'd0,   16'h0000, 16'h5555, 1'b0};
        vecs[10] = '{16'd256, 1'b0, 16'd0,   16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{16'd256, 1'b1, 16'd300, 16'hBEEF, 16'h0000, 1'b1};
        vecs[12] = '{16'd44,  1'b0, 16'd0,   16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{16'd7,   1'b0, 16'd0,   16'h0000, 16'h0000, 1'b0};
        vecs[14] = '{16'hFFFF,1'b0, 16'd0,   16'h0000, 16'h0000, 1'b1};
        vecs[15] = '{16'd255, 1'b0, 16'd0,   16'h0000, 16'h0000, 1'b0};
        vecs[16] = '{16'd1,   1'b0, 16'd0,   16'h0000, 16'hABCD, 1'b0};

        RST_N     = 1'b0;
        ReadAddr  = 16'd0;
        WriteEn   = 1'b1;
        WriteAddr = 16'd7;
        WriteData = 16'h7777;
        #1;
        check("reset_data", ReadData, 16'h0000);
        check("reset_err", {15'd0, AddrErr}, 16'h0000);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_hold_data", ReadData, 16'h0000);
        WriteEn = 1'b0;
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        #1;
        check("release_no_edge", ReadData, 16'h0000);
        @(posedge CLK);
        #1;
        check("first_read_mem0", ReadData, 16'h0000);

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d_data", i), ReadData, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), {15'd0, AddrErr}, {15'd0, vecs[i].exp_err});
        end

        #2;
        ReadAddr = 16'd3;
        #1;
        check("midcycle_addr_hidden", ReadData, 16'hABCD);
        RST_N = 1'b0;
        #1;
        check("async_reset_data", ReadData, 16'h0000);
        check("async_reset_err", {15'd0, AddrErr}, 16'h0000);
        ReadAddr = 16'd1;
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;
        #1;
        check("post_release_no_edge", ReadData, 16'h0000);
        @(posedge CLK);
        #1;
        check("contents_kept", ReadData, 16'hABCD);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] ra, wa, wd, ed;
            logic        we, ee;
            ra = 16'($urandom_range(0, 300));
            if (n % 37 == 0) ra = 16'($urandom);
            wa = 16'($urandom_range(0, 300));
            wd = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            ee = ra >= 16'd256;
            ed = ee ? 16'h0000 : model[ra[7:0]];
            cyc(ra, we, wa, wd);
            check("rand_data", ReadData, ed);
            check("rand_err", {15'd0, AddrErr}, {15'd0, ee});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
